// File: rtl/dmp_bus_master_if.sv
// Request/response handshake and coprocessor bus bundle for dmp_bus_master.
// The master modport is the bus master side; the slave modport is the requester plus the coprocessor.
interface dmp_bus_master_if;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_DIV;
   logic [15:0] REQ_A;
   logic [15:0] REQ_B;
   logic        RSP_VALID;
   logic        RSP_ACK;
   logic [15:0] RSP_Q;
   logic [15:0] RSP_R;
   logic        RSP_ERR;
   logic [2:0]  AB;
   logic [7:0]  DB_OUT;
   logic        DB_OE;
   logic [7:0]  DB_IN;
   logic        WR;
   logic        RD;

   modport master (
      input  REQ_VALID, REQ_DIV, REQ_A, REQ_B, RSP_ACK, DB_IN,
      output REQ_READY, RSP_VALID, RSP_Q, RSP_R, RSP_ERR, AB, DB_OUT, DB_OE, WR, RD
   );

   modport slave (
      output REQ_VALID, REQ_DIV, REQ_A, REQ_B, RSP_ACK, DB_IN,
      input  REQ_READY, RSP_VALID, RSP_Q, RSP_R, RSP_ERR, AB, DB_OUT, DB_OE, WR, RD
   );
endinterface

// File: rtl/dmp_bus_master.sv
// Sequences multiply/divide jobs onto an 8-bit coprocessor bus with two-cycle setup/strobe accesses.
// Divide support is built only when DMP_DIV_EN is defined; otherwise divide requests end with RSP_ERR.
module dmp_bus_master #(
   parameter int unsigned MUL_WAIT = 10,
   parameter int unsigned DIV_WAIT = 20
) (
   input  logic             CLK,
   input  logic             RES,
   dmp_bus_master_if.master bus,
   output logic             BUSY
);

`ifdef DMP_DIV_EN
   localparam logic DIV_EN_C = 1'b1;
`else
   localparam logic DIV_EN_C = 1'b0;
`endif

   localparam logic [15:0] MUL_LAST_C = 16'((MUL_WAIT > 0) ? MUL_WAIT - 1 : 0);
   localparam logic [15:0] DIV_LAST_C = 16'((DIV_WAIT > 0) ? DIV_WAIT - 1 : 0);
   localparam logic        MUL_ZERO_C = (MUL_WAIT == 0);
   localparam logic        DIV_ZERO_C = (DIV_WAIT == 0);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WSETUP  = 3'd1,
      WSTROBE = 3'd2,
      WAIT    = 3'd3,
      RSETUP  = 3'd4,
      RSTROBE = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t      state_r, state_s;
   logic [1:0]  step_r, step_s, last_step_s;
   logic [15:0] wait_cnt_r, wait_cnt_s, wait_last_s;
   logic        wait_zero_s;
   logic        accept_s;
   logic        is_div_r, unsup_r;
   logic [15:0] a_r, b_r, q_r, r_r;
   logic        div_sel_s;
   logic [15:0] a_sel_s, b_sel_s;
   logic [2:0]  ab_r, ab_s;
   logic [7:0]  db_out_r, db_out_s;
   logic        db_oe_r, wr_r, rd_r, busy_r, req_ready_r, rsp_valid_r, rsp_err_r;

   // Write address: multiply uses 0,1; divide uses 2..5 (divisor then dividend).
   function automatic logic [2:0] wr_addr(input logic div, input logic [1:0] step);
      if (div) begin
         wr_addr = 3'd2 + {1'b0, step};
      end else begin
         wr_addr = {2'b00, step[0]};
      end
   endfunction

   function automatic logic [7:0] wr_data(input logic div, input logic [1:0] step,
                                          input logic [15:0] a, input logic [15:0] b);
      case ({div, step})
         3'b000:  wr_data = a[7:0];
         3'b001:  wr_data = b[7:0];
         3'b100:  wr_data = b[7:0];
         3'b101:  wr_data = b[15:8];
         3'b110:  wr_data = a[7:0];
         3'b111:  wr_data = a[15:8];
         default: wr_data = 8'h00;
      endcase
   endfunction

   // Next-state logic; step counts byte accesses within the write or read phase.
   always_comb begin
      state_s     = state_r;
      step_s      = step_r;
      wait_cnt_s  = wait_cnt_r;
      accept_s    = 1'b0;
      last_step_s = is_div_r ? 2'd3 : 2'd1;
      wait_zero_s = is_div_r ? DIV_ZERO_C : MUL_ZERO_C;
      wait_last_s = is_div_r ? DIV_LAST_C : MUL_LAST_C;
      case (state_r)
         IDLE: begin
            if (bus.REQ_VALID) begin
               accept_s   = 1'b1;
               step_s     = 2'd0;
               wait_cnt_s = 16'd0;
               state_s    = (bus.REQ_DIV && !DIV_EN_C) ? WAIT : WSETUP;
            end else begin
               state_s = IDLE;
            end
         end
         WSETUP: state_s = WSTROBE;
         WSTROBE: begin
            if (step_r == last_step_s) begin
               step_s     = 2'd0;
               wait_cnt_s = 16'd0;
               state_s    = wait_zero_s ? RSETUP : WAIT;
            end else begin
               step_s  = step_r + 2'd1;
               state_s = WSETUP;
            end
         end
         WAIT: begin
            if (unsup_r) begin
               state_s = DONE;
            end else if (wait_cnt_r == wait_last_s) begin
               state_s = RSETUP;
            end else begin
               wait_cnt_s = wait_cnt_r + 16'd1;
            end
         end
         RSETUP: state_s = RSTROBE;
         RSTROBE: begin
            if (step_r == last_step_s) begin
               state_s = DONE;
            end else begin
               step_s  = step_r + 2'd1;
               state_s = RSETUP;
            end
         end
         DONE: begin
            if (bus.RSP_ACK) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Bus address/data for the upcoming cycle; operands come straight from the request on acceptance.
   always_comb begin
      div_sel_s = accept_s ? bus.REQ_DIV : is_div_r;
      a_sel_s   = accept_s ? bus.REQ_A : a_r;
      b_sel_s   = accept_s ? bus.REQ_B : b_r;
      ab_s      = ab_r;
      db_out_s  = db_out_r;
      if (state_s == WSETUP) begin
         ab_s     = wr_addr(div_sel_s, step_s);
         db_out_s = wr_data(div_sel_s, step_s, a_sel_s, b_sel_s);
      end else if (state_s == RSETUP) begin
         ab_s     = {1'b0, step_s};
         db_out_s = 8'h00;
      end else begin
         ab_s     = ab_r;
         db_out_s = db_out_r;
      end
   end

   // State, counters and latched request.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         state_r    <= IDLE;
         step_r     <= 2'd0;
         wait_cnt_r <= 16'd0;
         is_div_r   <= 1'b0;
         unsup_r    <= 1'b0;
         a_r        <= 16'h0000;
         b_r        <= 16'h0000;
      end else begin
         state_r    <= state_s;
         step_r     <= step_s;
         wait_cnt_r <= wait_cnt_s;
         if (accept_s) begin
            is_div_r <= bus.REQ_DIV;
            unsup_r  <= bus.REQ_DIV & ~DIV_EN_C;
            a_r      <= bus.REQ_A;
            b_r      <= bus.REQ_B;
         end
      end
   end

   // Result bytes are taken from DB_IN on the edge that ends each read strobe.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         q_r <= 16'h0000;
         r_r <= 16'h0000;
      end else if (accept_s) begin
         q_r <= 16'h0000;
         r_r <= 16'h0000;
      end else if (state_r == RSTROBE) begin
         case (step_r)
            2'd0:    q_r[7:0]  <= bus.DB_IN;
            2'd1:    q_r[15:8] <= bus.DB_IN;
            2'd2:    r_r[7:0]  <= bus.DB_IN;
            2'd3:    r_r[15:8] <= bus.DB_IN;
            default: q_r       <= q_r;
         endcase
      end
   end

   // Outputs registered from the next state so strobes are glitch-free.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         req_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         ab_r        <= 3'd0;
         db_out_r    <= 8'h00;
         db_oe_r     <= 1'b0;
         wr_r        <= 1'b1;
         rd_r        <= 1'b1;
      end else begin
         req_ready_r <= (state_s == IDLE);
         busy_r      <= (state_s != IDLE);
         rsp_valid_r <= (state_s == DONE);
         rsp_err_r   <= (state_s == DONE) && unsup_r;
         ab_r        <= ab_s;
         db_out_r    <= db_out_s;
         db_oe_r     <= (state_s == WSETUP) || (state_s == WSTROBE);
         wr_r        <= (state_s != WSTROBE);
         rd_r        <= (state_s != RSTROBE);
      end
   end

   assign bus.REQ_READY = req_ready_r;
   assign bus.RSP_VALID = rsp_valid_r;
   assign bus.RSP_Q     = q_r;
   assign bus.RSP_R     = r_r;
   assign bus.RSP_ERR   = rsp_err_r;
   assign bus.AB        = ab_r;
   assign bus.DB_OUT    = db_out_r;
   assign bus.DB_OE     = db_oe_r;
   assign bus.WR        = wr_r;
   assign bus.RD        = rd_r;
   assign BUSY          = busy_r;

endmodule

// File: tb/tb_dmp_bus_master.sv
// Scoreboard bench for dmp_bus_master: a coprocessor register model answers reads,
// expected bus writes and results are queued at stimulus time and popped when observed.
module tb_dmp_bus_master;
   logic CLK = 1'b0;
   logic RES;
   logic BUSY;
   int   total = 0;
   int   bad   = 0;
   int   rd_cnt;
   int   overlap;
   logic [7:0]  rd_mem [0:7];
   logic [10:0] exp_wr_q [$];
   logic [10:0] obs_wr_q [$];
   logic [32:0] exp_rsp_q [$];

   localparam logic [49:0] RST_VEC_C = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 8'h00,
                                        1'b0, 1'b1, 1'b1, 1'b0};

   dmp_bus_master_if bus ();

   dmp_bus_master dut (
      .CLK  (CLK),
      .RES  (RES),
      .bus  (bus),
      .BUSY (BUSY)
   );

   always #5 CLK = ~CLK;

   always_comb bus.DB_IN = rd_mem[bus.AB];

   function automatic logic [49:0] out_vec();
      return {bus.REQ_READY, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_Q, bus.RSP_R, bus.AB,
              bus.DB_OUT, bus.DB_OE, bus.WR, bus.RD, BUSY};
   endfunction

   // Records bus activity from just after acceptance until RSP_VALID, with a cycle bound.
   task automatic wait_rsp(output int lat);
      lat = -1;
      rd_cnt = 0;
      overlap = 0;
      obs_wr_q.delete();
      for (int k = 1; k <= 200; k++) begin
         @(posedge CLK);
         #1;
         if (!bus.WR) obs_wr_q.push_back({bus.AB, bus.DB_OUT});
         if (!bus.RD) rd_cnt++;
         if (!bus.WR && !bus.RD) overlap++;
         if (bus.RSP_VALID) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic issue(input logic div, input logic [15:0] a, input logic [15:0] b, output int lat);
      int k;
      @(negedge CLK);
      bus.REQ_VALID = 1'b1;
      bus.REQ_DIV   = div;
      bus.REQ_A     = a;
      bus.REQ_B     = b;
      k = 0;
      while (!bus.REQ_READY && k < 50) begin
         @(negedge CLK);
         k++;
      end
      @(posedge CLK);
      #1;
      bus.REQ_VALID = 1'b0;
      wait_rsp(lat);
   endtask

   task automatic ack();
      @(negedge CLK);
      bus.RSP_ACK = 1'b1;
      @(posedge CLK);
      #1;
      bus.RSP_ACK = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      RES = 1'b1;
      #2;
      RES = 1'b0;
      #1;
      total++;
      if (out_vec() !== RST_VEC_C) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=%h", out_vec(), RST_VEC_C);
      end
      repeat (2) @(posedge CLK);
      rd_mem[0] = 8'h11;
      rd_mem[1] = 8'h22;
      @(negedge CLK);
      RES = 1'b1;
      bus.REQ_VALID = 1'b1;
      bus.REQ_DIV   = 1'b0;
      bus.REQ_A     = 16'h0005;
      bus.REQ_B     = 16'h0006;
      @(posedge CLK);
      #1;
      bus.REQ_VALID = 1'b0;
      total++;
      if ({BUSY, bus.REQ_READY} !== 2'b10) begin
         bad++;
         $display("FAIL first_accept got=%b exp=10", {BUSY, bus.REQ_READY});
      end
      exp_rsp_q.push_back({1'b0, 16'h2211, 16'h0000});
      wait_rsp(lat);
      total++;
      if (lat !== 18) begin
         bad++;
         $display("FAIL first_latency got=%0d exp=18", lat);
      end
      total++;
      if ({bus.RSP_ERR, bus.RSP_Q, bus.RSP_R} !== exp_rsp_q[0]) begin
         bad++;
         $display("FAIL first_result got=%h exp=%h", {bus.RSP_ERR, bus.RSP_Q, bus.RSP_R}, exp_rsp_q[0]);
      end
      void'(exp_rsp_q.pop_front());
      ack();
   endtask

   task automatic test_multiply(input logic [15:0] a, input logic [15:0] b,
                                input logic [7:0] lo, input logic [7:0] hi);
      int lat;
      logic [10:0] e;
      logic [10:0] o;
      logic [32:0] er;
      rd_mem[0] = lo;
      rd_mem[1] = hi;
      exp_wr_q.push_back({3'd0, a[7:0]});
      exp_wr_q.push_back({3'd1, b[7:0]});
      exp_rsp_q.push_back({1'b0, hi, lo, 16'h0000});
      issue(1'b0, a, b, lat);
      total++;
      if (lat !== 18) begin
         bad++;
         $display("FAIL mul_latency got=%0d exp=18", lat);
      end
      total++;
      if (obs_wr_q.size() != exp_wr_q.size()) begin
         bad++;
         $display("FAIL mul_wr_count got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size());
      end
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front();
         o = obs_wr_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL mul_write got=ab%0d:%h exp=ab%0d:%h", o[10:8], o[7:0], e[10:8], e[7:0]);
         end
      end
      exp_wr_q.delete();
      total++;
      if (rd_cnt !== 2 || overlap !== 0) begin
         bad++;
         $display("FAIL mul_strobes got=rd%0d/ovl%0d exp=rd2/ovl0", rd_cnt, overlap);
      end
      er = exp_rsp_q.pop_front();
      total++;
      if ({bus.RSP_ERR, bus.RSP_Q, bus.RSP_R} !== er) begin
         bad++;
         $display("FAIL mul_result got=%h exp=%h", {bus.RSP_ERR, bus.RSP_Q, bus.RSP_R}, er);
      end
      ack();
   endtask

`ifdef DMP_DIV_EN
   task automatic test_divide();
      int lat;
      logic [10:0] e;
      logic [10:0] o;
      logic [32:0] er;
      rd_mem[0] = 8'h8E;
      rd_mem[1] = 8'h00;
      rd_mem[2] = 8'h06;
      rd_mem[3] = 8'h00;
      exp_wr_q.push_back({3'd2, 8'h07});
      exp_wr_q.push_back({3'd3, 8'h00});
      exp_wr_q.push_back({3'd4, 8'hE8});
      exp_wr_q.push_back({3'd5, 8'h03});
      exp_rsp_q.push_back({1'b0, 16'h008E, 16'h0006});
      issue(1'b1, 16'd1000, 16'd7, lat);
      total++;
      if (lat !== 36) begin
         bad++;
         $display("FAIL div_latency got=%0d exp=36", lat);
      end
      total++;
      if (obs_wr_q.size() != exp_wr_q.size()) begin
         bad++;
         $display("FAIL div_wr_count got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size());
      end
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front();
         o = obs_wr_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL div_write got=ab%0d:%h exp=ab%0d:%h", o[10:8], o[7:0], e[10:8], e[7:0]);
         end
      end
      exp_wr_q.delete();
      total++;
      if (rd_cnt !== 4 || overlap !== 0) begin
         bad++;
         $display("FAIL div_strobes got=rd%0d/ovl%0d exp=rd4/ovl0", rd_cnt, overlap);
      end
      er = exp_rsp_q.pop_front();
      total++;
      if ({bus.RSP_ERR, bus.RSP_Q, bus.RSP_R} !== er) begin
         bad++;
         $display("FAIL div_result got=%h exp=%h", {bus.RSP_ERR, bus.RSP_Q, bus.RSP_R}, er);
      end
      ack();
   endtask
`else
   task automatic test_div_unsupported();
      int lat;
      logic [32:0] er;
      exp_rsp_q.push_back({1'b1, 16'h0000, 16'h0000});
      issue(1'b1, 16'd1000, 16'd7, lat);
      total++;
      if (lat !== 1) begin
         bad++;
         $display("FAIL unsup_latency got=%0d exp=1", lat);
      end
      total++;
      if (obs_wr_q.size() != 0 || rd_cnt !== 0) begin
         bad++;
         $display("FAIL unsup_bus got=wr%0d/rd%0d exp=wr0/rd0", obs_wr_q.size(), rd_cnt);
      end
      er = exp_rsp_q.pop_front();
      total++;
      if ({bus.RSP_ERR, bus.RSP_Q, bus.RSP_R} !== er) begin
         bad++;
         $display("FAIL unsup_result got=%h exp=%h", {bus.RSP_ERR, bus.RSP_Q, bus.RSP_R}, er);
      end
      ack();
      total++;
      if ({bus.RSP_ERR, bus.RSP_VALID, bus.REQ_READY} !== 3'b001) begin
         bad++;
         $display("FAIL unsup_clear got=%b exp=001", {bus.RSP_ERR, bus.RSP_VALID, bus.REQ_READY});
      end
   endtask
`endif

   task automatic test_ack_ignored();
      int lat;
      logic [32:0] er;
      rd_mem[0] = 8'h3C;
      rd_mem[1] = 8'h00;
      exp_rsp_q.push_back({1'b0, 16'h003C, 16'h0000});
      @(negedge CLK);
      bus.RSP_ACK = 1'b1;
      issue(1'b0, 16'h0006, 16'h000A, lat);
      total++;
      if (lat !== 18) begin
         bad++;
         $display("FAIL ackign_latency got=%0d exp=18", lat);
      end
      er = exp_rsp_q.pop_front();
      total++;
      if ({bus.RSP_ERR, bus.RSP_Q, bus.RSP_R} !== er) begin
         bad++;
         $display("FAIL ackign_result got=%h exp=%h", {bus.RSP_ERR, bus.RSP_Q, bus.RSP_R}, er);
      end
      @(posedge CLK);
      #1;
      bus.RSP_ACK = 1'b0;
      total++;
      if ({bus.RSP_VALID, bus.REQ_READY} !== 2'b01) begin
         bad++;
         $display("FAIL ackign_exit got=%b exp=01", {bus.RSP_VALID, bus.REQ_READY});
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [10:0] e;
      logic [10:0] o;
      logic [32:0] er;
      rd_mem[0] = 8'h55;
      rd_mem[1] = 8'hAA;
      exp_rsp_q.push_back({1'b0, 16'hAA55, 16'h0000});
      issue(1'b0, 16'h0102, 16'h0304, lat);
      er = exp_rsp_q.pop_front();
      total++;
      if (lat !== 18 || {bus.RSP_ERR, bus.RSP_Q, bus.RSP_R} !== er) begin
         bad++;
         $display("FAIL b2b_first got=%0d/%h exp=18/%h", lat, {bus.RSP_ERR, bus.RSP_Q, bus.RSP_R}, er);
      end
      @(negedge CLK);
      bus.REQ_VALID = 1'b1;
      bus.REQ_DIV   = 1'b0;
      bus.REQ_A     = 16'h0506;
      bus.REQ_B     = 16'h0708;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         #1;
         total++;
         if ({bus.RSP_VALID, bus.REQ_READY, bus.RSP_Q, bus.RSP_R} !== {1'b1, 1'b0, er[31:0]}) begin
            bad++;
            $display("FAIL hold_%0d got=%b%b_%h exp=10_%h", i, bus.RSP_VALID, bus.REQ_READY,
                     {bus.RSP_Q, bus.RSP_R}, er[31:0]);
         end
      end
      exp_wr_q.push_back({3'd0, 8'h06});
      exp_wr_q.push_back({3'd1, 8'h08});
      exp_rsp_q.push_back({1'b0, 16'hAA55, 16'h0000});
      ack();
      total++;
      if ({bus.REQ_READY, BUSY, bus.RSP_VALID} !== 3'b100) begin
         bad++;
         $display("FAIL b2b_ack_edge got=%b exp=100", {bus.REQ_READY, BUSY, bus.RSP_VALID});
      end
      @(posedge CLK);
      #1;
      bus.REQ_VALID = 1'b0;
      total++;
      if ({bus.REQ_READY, BUSY} !== 2'b01) begin
         bad++;
         $display("FAIL b2b_accept got=%b exp=01", {bus.REQ_READY, BUSY});
      end
      wait_rsp(lat);
      total++;
      if (lat !== 18 || overlap !== 0) begin
         bad++;
         $display("FAIL b2b_second got=lat%0d/ovl%0d exp=lat18/ovl0", lat, overlap);
      end
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front();
         o = obs_wr_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL b2b_write got=ab%0d:%h exp=ab%0d:%h", o[10:8], o[7:0], e[10:8], e[7:0]);
         end
      end
      total++;
      if (exp_wr_q.size() != 0 || obs_wr_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_wr_count got=left%0d/%0d exp=0/0", exp_wr_q.size(), obs_wr_q.size());
      end
      exp_wr_q.delete();
      er = exp_rsp_q.pop_front();
      total++;
      if ({bus.RSP_ERR, bus.RSP_Q, bus.RSP_R} !== er) begin
         bad++;
         $display("FAIL b2b_result got=%h exp=%h", {bus.RSP_ERR, bus.RSP_Q, bus.RSP_R}, er);
      end
      ack();
   endtask

   task automatic test_mid_reset();
      logic found;
      @(negedge CLK);
      bus.REQ_VALID = 1'b1;
      bus.REQ_DIV   = 1'b0;
      bus.REQ_A     = 16'h0012;
      bus.REQ_B     = 16'h0034;
      @(posedge CLK);
      #1;
      bus.REQ_VALID = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK);
         #1;
         if (!bus.WR && bus.AB == 3'd1) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (found !== 1'b1) begin
         bad++;
         $display("FAIL midrst_strobe got=%b exp=1", found);
      end
      RES = 1'b0;
      #1;
      total++;
      if (out_vec() !== RST_VEC_C) begin
         bad++;
         $display("FAIL midrst_outputs got=%h exp=%h", out_vec(), RST_VEC_C);
      end
      @(negedge CLK);
      RES = 1'b1;
      test_multiply(16'h0012, 16'h0034, 8'hA8, 8'h03);
   endtask

   initial begin
      RES = 1'b1;
      bus.REQ_VALID = 1'b0;
      bus.REQ_DIV   = 1'b0;
      bus.REQ_A     = 16'h0000;
      bus.REQ_B     = 16'h0000;
      bus.RSP_ACK   = 1'b0;
      for (int i = 0; i < 8; i++) rd_mem[i] = 8'h00;
      test_reset();
      test_multiply(16'h0012, 16'h0034, 8'hA8, 8'h03);
      test_multiply(16'hABFF, 16'h1280, 8'h00, 8'hFF);
`ifdef DMP_DIV_EN
      test_divide();
`else
      test_div_unsupported();
`endif
      test_ack_ignored();
      test_back_to_back();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmp_bus_master.md
DMP_BUS_MASTER -- requirements
Module: dmp_bus_master

Interface
REQ-001 The parameter MUL_WAIT SHALL default to 10 and SHALL set the idle cycles between the multiply start write and the first result read.
REQ-002 The parameter DIV_WAIT SHALL default to 20 and SHALL set the idle cycles between the divide start write and the first result read.
REQ-003 The port CLK SHALL be an input, 1 bit, and the single clock; all state SHALL update on the rising edge.
REQ-004 The port RES SHALL be an input, 1 bit, and the asynchronous active-low reset.
REQ-005 The port REQ_VALID SHALL be an input, 1 bit, and SHALL signal that a request is offered.
REQ-006 The port REQ_READY SHALL be an output, 1 bit, and SHALL signal that a request can be accepted.
REQ-007 The port REQ_DIV SHALL be an input, 1 bit: 0 selects multiply, 1 selects divide.
REQ-008 The ports REQ_A and REQ_B SHALL be inputs, 16 bits each: REQ_A is the multiplicand or dividend, REQ_B the multiplier or divisor.
REQ-009 The port RSP_VALID SHALL be an output, 1 bit, and SHALL signal that a result is held.
REQ-010 The port RSP_ACK SHALL be an input, 1 bit, and SHALL signal that the result is consumed.
REQ-011 The ports RSP_Q and RSP_R SHALL be outputs, 16 bits each: RSP_Q is the product or quotient, RSP_R the remainder.
REQ-012 The port RSP_ERR SHALL be an output, 1 bit, and SHALL flag an unsupported request.
REQ-013 The port AB SHALL be an output, 3 bits, and SHALL carry the coprocessor register address.
REQ-014 The port DB_OUT SHALL be an output, 8 bits, and the port DB_OE SHALL be an output, 1 bit; DB_OE is the write data enable.
REQ-015 The port DB_IN SHALL be an input, 8 bits, and SHALL carry read data.
REQ-016 The ports WR and RD SHALL be outputs, 1 bit each, and active-low strobes.
REQ-017 The port BUSY SHALL be an output, 1 bit, and SHALL be high in every state other than IDLE.

Function
REQ-018 A request SHALL be accepted on the rising edge where REQ_VALID=1 and REQ_READY=1, with REQ_READY=1 only in IDLE; operands SHALL be latched at that edge.
REQ-019 The FSM states SHALL be IDLE, WSETUP, WSTROBE, WAIT, RSETUP, RSTROBE and DONE.
REQ-020 Each bus access SHALL take two cycles, a setup cycle and a strobe cycle; AB and DB_OUT SHALL be stable across both cycles.
REQ-021 In the strobe cycle, WR or RD SHALL be 0; in every other cycle both SHALL be 1, and WR and RD SHALL never be 0 together.
REQ-022 A multiply SHALL write AB=0 with REQ_A[7:0], then AB=1 with REQ_B[7:0] (the start write); it SHALL then wait MUL_WAIT cycles and read AB=0 into RSP_Q[7:0], then AB=1 into RSP_Q[15:8]; RSP_R SHALL be 0.
REQ-023 A divide SHALL write AB=2,3 with REQ_B low then high byte, and AB=4,5 with REQ_A low then high byte, where AB=5 is the start write; it SHALL then wait DIV_WAIT cycles and read AB=0,1 into RSP_Q low/high and AB=2,3 into RSP_R low/high.
REQ-024 Read data SHALL be sampled from DB_IN at the end of the RSTROBE cycle.
REQ-025 A multiply SHALL raise RSP_VALID exactly 8+MUL_WAIT cycles after acceptance, i.e. 18 cycles by default.
REQ-026 A divide SHALL raise RSP_VALID exactly 16+DIV_WAIT cycles after acceptance, i.e. 36 cycles by default.
REQ-027 In DONE, RSP_VALID and the result SHALL hold unchanged until an edge with RSP_ACK=1; the FSM SHALL return to IDLE at that edge.
REQ-028 RSP_ACK SHALL be ignored outside DONE.
REQ-029 A request SHALL be acceptable in the cycle after DONE exits.
REQ-030 The WAIT count SHALL be zero-based; a parameter value of 0 SHALL go directly from the start strobe to RSETUP.
REQ-031 A divide with REQ_B=0 SHALL still be issued on the bus, and the returned bytes SHALL be passed through unmodified.

Reset
REQ-032 RES=0 SHALL immediately force IDLE with REQ_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_Q=0, RSP_R=0, AB=0, DB_OUT=0, DB_OE=0, WR=1, RD=1 and BUSY=0, including when asserted mid-strobe.
REQ-033 After RES is released, the first request SHALL be acceptable at the first rising edge.

Configuration
REQ-034 With DMP_DIV_EN defined, divide SHALL behave as in REQ-023.
REQ-035 With DMP_DIV_EN undefined, a request with REQ_DIV=1 SHALL be accepted and SHALL enter DONE at the next edge with RSP_ERR=1, RSP_Q=0 and RSP_R=0, performing no bus cycles; RSP_ERR SHALL clear on leaving DONE.

Verification
REQ-036 Multiply A=0x0012, B=0x0034, with the bus model returning 0xA8 at AB=0 and 0x03 at AB=1 -> bus writes (0,0x12),(1,0x34); RSP_Q=0x03A8 and RSP_R=0 on cycle 18.
REQ-037 Divide A=1000, B=7, with the bus model returning quotient 142 and remainder 6 -> bus writes (2,0x07),(3,0x00),(4,0xE8),(5,0x03); RSP_Q=0x008E and RSP_R=0x0006 on cycle 36.
REQ-038 Hold RSP_ACK=0 for 5 cycles after RSP_VALID rises -> result stable and REQ_READY=0 throughout; accepted again the cycle after the ACK edge.
REQ-039 Assert RES=0 during the strobe of the AB=1 write -> WR=1 and BUSY=0 immediately; the next multiply completes correctly.
REQ-040 Issue back-to-back multiplies with REQ_VALID held high -> second acceptance one cycle after ACK; no overlapping strobes.
REQ-041 Build without DMP_DIV_EN and issue a divide -> no WR/RD activity; RSP_ERR=1 and RSP_VALID=1 one cycle after acceptance.
